// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the multi-format UART receiver.
//   rx_state_t      : receiver FSM states
//   MIN_PRESCALE    : smallest usable ticks-per-bit
//   MIN_DATA_LEN    : smallest data field length
//   PAR_EVEN/PAR_ODD: encodings of cfg_par_type
//   clamp_data_len  : folds a requested data length into the legal range
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    localparam int   MIN_PRESCALE = 4;
    localparam int   MIN_DATA_LEN = 5;
    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;

    function automatic logic [3:0] clamp_data_len(input logic [3:0] len, input int max_len);
        if (int'(len) < MIN_DATA_LEN) begin
            return 4'(MIN_DATA_LEN);
        end else if (int'(len) > max_len) begin
            return 4'(max_len);
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Front end of the receiver: synchronises the serial line, detects the start
// edge, runs the per-bit tick counter and produces one decision per bit.
//   clk, rst    : clock, synchronous active-low reset
//   rx_in       : asynchronous serial line (idle high)
//   active      : receiver is inside a frame (tick counter runs)
//   prescale    : latched, even ticks-per-bit (>= 4)
//   start_edge  : synchronised 1->0 transition on the line
//   bit_strobe  : one-cycle pulse at the decision point of each bit
//   bit_value   : decided bit value, valid with bit_strobe
// Build option UART_RX_MAJORITY_EN: decide by 2-of-3 vote of ticks
// P/2-1, P/2, P/2+1 (at tick P/2+1) instead of a single sample at P/2.
// ---------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  active,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  start_edge,
    output logic                  bit_strobe,
    output logic                  bit_value
);

    logic [1:0]            sync_q;
    logic                  rx_prev;
    logic [PRESCALE_W-1:0] tick;
    logic [PRESCALE_W-1:0] half;

    assign half = prescale >> 1;

    // Two-flop synchroniser plus one history flop for edge detection; all
    // reset to the idle (high) line level so reset never fakes a start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            rx_prev <= sync_q[1];
        end
    end

    // Requiring a real 1->0 transition also means a line held low after a
    // break cannot start a new frame until it has returned high.
    assign start_edge = rx_prev & ~sync_q[1];

    // The start-detect cycle is tick 0, so while idle the counter waits at 1,
    // ready for the first cycle inside the frame.
    always_ff @(posedge clk) begin
        if (!rst || !active) begin
            tick <= PRESCALE_W'(1);
        end else if (tick == prescale - 1'b1) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early;

    // Capture the two earlier votes; the third is the live sample at P/2+1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            early <= 2'b11;
        end else begin
            if (tick == half - 1'b1) early[0] <= sync_q[1];
            if (tick == half)        early[1] <= sync_q[1];
        end
    end

    assign bit_strobe = active && (tick == half + 1'b1);
    assign bit_value  = (early[0] & early[1]) | (early[0] & sync_q[1]) | (early[1] & sync_q[1]);
`else
    assign bit_strobe = active && (tick == half);
    assign bit_value  = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx_mf.sv
// ---------------------------------------------------------------------------
// uart_rx_mf
// Multi-format UART receiver: 5..D_WIDTH_MAX data bits, optional even/odd
// parity, 1 or 2 stop bits, runtime even prescale, ready/valid output with
// overrun and break reporting.
//   clk, rst       : oversampling clock, synchronous active-low reset
//   rx_in          : asynchronous serial line, idle high
//   cfg_*          : frame format, latched at start detection
//   rx_ready       : consumer accepts rx_data
//   rx_data        : received word, right-aligned, upper bits zero
//   rx_valid       : rx_data valid, held until accepted
//   parity_error   : qualifies rx_data
//   framing_error  : qualifies rx_data
//   overrun_error  : one-cycle pulse, completed frame dropped
//   break_det      : one-cycle pulse, break received
// Build option UART_RX_MAJORITY_EN selects majority-vote bit decisions in
// the sampler; everything else is identical.
// ---------------------------------------------------------------------------
module uart_rx_mf
    import uart_pkg::*;
#(
    parameter int D_WIDTH_MAX = 9,
    parameter int PRESCALE_W  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_in,
    input  logic [PRESCALE_W-1:0]  cfg_prescale,
    input  logic [3:0]             cfg_data_len,
    input  logic                   cfg_par_en,
    input  logic                   cfg_par_type,
    input  logic                   cfg_stop2,
    input  logic                   rx_ready,
    output logic [D_WIDTH_MAX-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   parity_error,
    output logic                   framing_error,
    output logic                   overrun_error,
    output logic                   break_det
);

    rx_state_t             state, state_nxt;
    logic [PRESCALE_W-1:0] prescale_even, prescale_eff, prescale_l;
    logic [3:0]            len_l;
    logic                  par_en_l, par_odd_l, stop2_l;
    logic [D_WIDTH_MAX-1:0] shreg;
    logic [3:0]            bit_idx;
    logic                  par_acc, par_bit, par_err_q, frm_err_q;
    logic                  start_edge, bit_strobe, bit_value;
    logic                  frame_done, frame_break, frm_err_final;
    logic                  start_accept, hold_blocked;

    assign prescale_even = {cfg_prescale[PRESCALE_W-1:1], 1'b0};
    assign prescale_eff  = (prescale_even < PRESCALE_W'(MIN_PRESCALE)) ?
                           PRESCALE_W'(MIN_PRESCALE) : prescale_even;
    assign start_accept  = (state == ST_IDLE) && start_edge;
    assign hold_blocked  = rx_valid && !rx_ready;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .active     (state != ST_IDLE),
        .prescale   (prescale_l),
        .start_edge (start_edge),
        .bit_strobe (bit_strobe),
        .bit_value  (bit_value)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus frame-end qualification. The final stop decision drops
    // straight back to IDLE so a start edge in the second half of the stop
    // bit is caught.
    always_comb begin
        state_nxt     = state;
        frame_done    = 1'b0;
        frame_break   = 1'b0;
        frm_err_final = frm_err_q;
        case (state)
            ST_IDLE: begin
                if (start_edge) state_nxt = ST_START;
            end
            ST_START: begin
                if (bit_strobe) state_nxt = bit_value ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_strobe && (bit_idx == len_l - 4'd1)) begin
                    state_nxt = par_en_l ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (bit_strobe) state_nxt = ST_STOP1;
            end
            ST_STOP1: begin
                if (bit_strobe) begin
                    if (!bit_value && (shreg == '0) && !par_bit) begin
                        frame_break = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else if (stop2_l) begin
                        state_nxt = ST_STOP2;
                    end else begin
                        frame_done    = 1'b1;
                        frm_err_final = ~bit_value;
                        state_nxt     = ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (bit_strobe) begin
                    frame_done    = 1'b1;
                    frm_err_final = frm_err_q | ~bit_value;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame datapath: configuration is frozen at start detection, then each
    // bit decision feeds the shifter, the parity accumulator or the stop
    // check. par_bit stays 0 without parity so the break test still works.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prescale_l <= PRESCALE_W'(MIN_PRESCALE);
            len_l      <= 4'(MIN_DATA_LEN);
            par_en_l   <= 1'b0;
            par_odd_l  <= 1'b0;
            stop2_l    <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            par_acc    <= 1'b0;
            par_bit    <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else if (start_accept) begin
            prescale_l <= prescale_eff;
            len_l      <= clamp_data_len(cfg_data_len, D_WIDTH_MAX);
            par_en_l   <= cfg_par_en;
            par_odd_l  <= (cfg_par_type == PAR_ODD);
            stop2_l    <= cfg_stop2;
            shreg      <= '0;
            bit_idx    <= '0;
            par_acc    <= 1'b0;
            par_bit    <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else if (bit_strobe) begin
            case (state)
                ST_DATA: begin
                    shreg   <= shreg | (D_WIDTH_MAX'(bit_value) << bit_idx);
                    par_acc <= par_acc ^ bit_value;
                    bit_idx <= bit_idx + 4'd1;
                end
                ST_PARITY: begin
                    par_bit   <= bit_value;
                    par_err_q <= (bit_value != (par_acc ^ par_odd_l));
                end
                ST_STOP1: begin
                    frm_err_q <= ~bit_value;
                end
                default: ;
            endcase
        end
    end

    // Holding register and status pulses. A completing frame is dropped with
    // an overrun pulse only while an unaccepted word is held; otherwise the
    // load wins over a simultaneous transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
            break_det     <= 1'b0;
        end else begin
            break_det     <= frame_break;
            overrun_error <= frame_done && hold_blocked;
            if (frame_done && !hold_blocked) begin
                rx_data       <= shreg;
                parity_error  <= par_err_q;
                framing_error <= frm_err_final;
                rx_valid      <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_mf.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_mf
// Self-checking bench for uart_rx_mf. Frames are described as a bit list
// built from the frame format, driven one tick per negedge, and the expected
// word, error flags and rx_valid rise time are computed from that format.
// ---------------------------------------------------------------------------
module tb_uart_rx_mf;

    localparam int DW = 9;
    localparam int PW = 6;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_in = 1'b1;
    logic [PW-1:0] cfg_prescale = PW'(16);
    logic [3:0]    cfg_data_len = 4'd8;
    logic          cfg_par_en = 1'b0;
    logic          cfg_par_type = 1'b0;
    logic          cfg_stop2 = 1'b0;
    logic          rx_ready = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid, parity_error, framing_error, overrun_error, break_det;

    uart_rx_mf #(.D_WIDTH_MAX(DW), .PRESCALE_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_in         (rx_in),
        .cfg_prescale  (cfg_prescale),
        .cfg_data_len  (cfg_data_len),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_type  (cfg_par_type),
        .cfg_stop2     (cfg_stop2),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .break_det     (break_det)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    // Free-running posedge count used for latency expectations.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: counts rx_valid rises, high cycles and status pulses.
    int   valid_rises = 0, valid_high = 0, break_pulses = 0, overrun_pulses = 0;
    int   last_rise_cyc = -1;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && !valid_prev) begin
            valid_rises++;
            last_rise_cyc = cyc;
        end
        if (rx_valid) valid_high++;
        if (break_det) break_pulses++;
        if (overrun_error) overrun_pulses++;
        valid_prev = rx_valid;
    end

    // Reference expectations for the most recent frame.
    logic [DW-1:0] exp_data;
    logic          exp_pe, exp_fe;
    int            exp_rise_cyc, rise_base, brk_base, ovr_base, high_base;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        assert (obs === expv) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one frame. The bit list and expectations come from the format:
    // effective prescale, clamped length, parity rule and stop bit values.
    task automatic applyStimulus(input int p_cfg, input int len_cfg, input logic par_en,
                                 input logic par_odd, input logic two_stop,
                                 input logic [DW-1:0] data, input logic corrupt_par,
                                 input logic stop1_val, input logic stop2_val,
                                 input int glitch_bit, input logic scramble);
        int            p, len, final_idx;
        logic          par_sent;
        logic [DW-1:0] sent;
        logic          bits[$];
        p = p_cfg & ~1;
        if (p < 4) p = 4;
        len = (len_cfg < 5) ? 5 : ((len_cfg > DW) ? DW : len_cfg);
        sent = data & DW'((1 << len) - 1);
        par_sent = ((($countones(sent) % 2) == 1) ^ par_odd) ^ corrupt_par;
        exp_data = sent;
        if (glitch_bit >= 1 && MAJ == 0) exp_data[glitch_bit-1] = ~exp_data[glitch_bit-1];
        exp_pe = par_en && (par_sent != ((($countones(exp_data) % 2) == 1) ^ par_odd));
        exp_fe = !stop1_val || (two_stop && !stop2_val);
        final_idx = len + int'(par_en) + int'(two_stop) + 1;
        cfg_prescale = PW'(p_cfg);
        cfg_data_len = 4'(len_cfg);
        cfg_par_en   = par_en;
        cfg_par_type = par_odd;
        cfg_stop2    = two_stop;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < len; i++) bits.push_back(sent[i]);
        if (par_en) bits.push_back(par_sent);
        bits.push_back(stop1_val);
        if (two_stop) bits.push_back(stop2_val);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rise_base = valid_rises;
        brk_base  = break_pulses;
        ovr_base  = overrun_pulses;
        high_base = valid_high;
        exp_rise_cyc = cyc + 3 + final_idx * p + p / 2 + MAJ;
        for (int b = 0; b < bits.size(); b++) begin
            for (int t = 0; t < p; t++) begin
                if (scramble && b == 1 && t == 0) begin
                    cfg_prescale = PW'($urandom);
                    cfg_data_len = 4'($urandom);
                    cfg_par_en   = 1'($urandom);
                    cfg_par_type = 1'($urandom);
                    cfg_stop2    = 1'($urandom);
                end
                rx_in = bits[b] ^ ((b == glitch_bit) && (t == p / 2));
                @(negedge clk);
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic checkFrame(input string tag);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_data"}, 32'(rx_data), 32'(exp_data));
        checkOutput({tag, "_perr"}, 32'(parity_error), 32'(exp_pe));
        checkOutput({tag, "_ferr"}, 32'(framing_error), 32'(exp_fe));
        checkOutput({tag, "_rises"}, 32'(valid_rises - rise_base), 32'd1);
        checkOutput({tag, "_latency"}, 32'(last_rise_cyc), 32'(exp_rise_cyc));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rb, bb, ob;
        logic [DW-1:0] rdata;
        int rlen;
        logic rs1;

        // Reset state
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("reset_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_data", 32'(rx_data), 32'd0);
        checkOutput("reset_perr", 32'(parity_error), 32'd0);
        checkOutput("reset_ferr", 32'(framing_error), 32'd0);
        checkOutput("reset_ovr", 32'(overrun_error), 32'd0);
        checkOutput("reset_brk", 32'(break_det), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1, P=16, 0xA5
        applyStimulus(16, 8, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        checkFrame("8n1_a5");
        checkOutput("8n1_a5_const", 32'(rx_data), 32'h0A5);
        checkOutput("8n1_a5_pulse_width", 32'(valid_high - high_base), 32'd1);

        // 7E2, P=8, 0x55, wrong parity, second stop bit low
        applyStimulus(8, 7, 1'b1, 1'b0, 1'b1, 9'h055, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        checkFrame("7e2_55");
        checkOutput("7e2_55_perr_const", 32'(parity_error), 32'd1);
        checkOutput("7e2_55_ferr_const", 32'(framing_error), 32'd1);

        // Start glitch of 3 ticks, then a good frame
        cfg_prescale = PW'(16);
        rb = valid_rises;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_no_valid", 32'(valid_rises - rb), 32'd0);
        applyStimulus(16, 8, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        checkFrame("after_glitch_3c");

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        applyStimulus(16, 8, 1'b0, 1'b0, 1'b0, 9'h011, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        checkFrame("ovr_first");
        rb = rise_base;
        applyStimulus(16, 8, 1'b0, 1'b0, 1'b0, 9'h022, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("ovr_hold_data", 32'(rx_data), 32'h011);
        checkOutput("ovr_hold_valid", 32'(rx_valid), 32'd1);
        checkOutput("ovr_pulses", 32'(overrun_pulses - ovr_base), 32'd1);
        checkOutput("ovr_rises", 32'(valid_rises - rb), 32'd1);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("ovr_accept_clears", 32'(rx_valid), 32'd0);

        // 9O1, P=32, 0x1FF, then break for two frame times
        applyStimulus(32, 9, 1'b1, 1'b1, 1'b0, 9'h1FF, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        checkFrame("9o1_1ff");
        rb = valid_rises;
        bb = break_pulses;
        rx_in = 1'b0;
        repeat (2 * (1 + 9 + 1 + 1) * 32) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("break_pulses", 32'(break_pulses - bb), 32'd1);
        checkOutput("break_no_valid", 32'(valid_rises - rb), 32'd0);

        // One-tick glitch on data bit 3 of 0x00
        applyStimulus(16, 8, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        checkFrame("glitch_bit3");
        checkOutput("glitch_bit3_const", 32'(rx_data), (MAJ == 1) ? 32'h000 : 32'h008);

        // Reset in the middle of a frame delivers nothing
        cfg_prescale = PW'(16);
        rb = valid_rises;
        bb = break_pulses;
        ob = overrun_pulses;
        rx_in = 1'b0;
        repeat (48) @(negedge clk);
        rst = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("midreset_no_valid", 32'(valid_rises - rb), 32'd0);
        checkOutput("midreset_no_break", 32'(break_pulses - bb), 32'd0);
        checkOutput("midreset_valid_low", 32'(rx_valid), 32'd0);
        checkOutput("midreset_no_ovr", 32'(overrun_pulses - ob), 32'd0);

        // Randomised formats, including out-of-range prescale/length and
        // configuration changes while a frame is in flight
        for (int n = 0; n < 20; n++) begin
            int p_cfg, len_cfg;
            p_cfg   = int'($urandom_range(0, 63));
            len_cfg = int'($urandom_range(0, 15));
            rdata   = DW'($urandom);
            rlen    = (len_cfg < 5) ? 5 : ((len_cfg > DW) ? DW : len_cfg);
            rs1     = 1'($urandom_range(0, 3) != 0);
            if ((rdata & DW'((1 << rlen) - 1)) == '0) rs1 = 1'b1;
            applyStimulus(p_cfg, len_cfg, 1'($urandom), 1'($urandom), 1'($urandom), rdata,
                          1'($urandom_range(0, 3) == 0), rs1, 1'($urandom_range(0, 3) != 0),
                          -1, 1'b1);
            checkFrame($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_mf.md
Name: uart_rx_mf

Overview:
Parametrised next-generation UART receiver for the UART subsystem, single clock domain at the oversampling clock.
- Adds runtime data length (5..D_WIDTH_MAX), 1 or 2 stop bits and any even prescale.
- Adds an input synchroniser, start-glitch rejection, a ready/valid output handshake, overrun detection and break detection.
- Drop-in successor to the current receiver behind the UART top level.

Parameters:
D_WIDTH_MAX, 9, widest supported data field; rx_data width
PRESCALE_W, 6, width of cfg_prescale

Ports:
clk  in  1  oversampling clock (prescale ticks per bit)
rst  in  1  synchronous reset, active-low
rx_in  in  1  asynchronous serial line, idle high
cfg_prescale  in  PRESCALE_W  ticks per bit; even, 4..62
cfg_data_len  in  4  data bits per frame, 5..D_WIDTH_MAX
cfg_par_en  in  1  parity bit present
cfg_par_type  in  1  0 = even, 1 = odd
cfg_stop2  in  1  two stop bits
rx_ready  in  1  consumer accepts rx_data
rx_data  out  D_WIDTH_MAX  received word, LSB-first, right-aligned, upper bits 0
rx_valid  out  1  rx_data valid, held until accepted
parity_error  out  1  qualifies rx_data; valid while rx_valid
framing_error  out  1  qualifies rx_data; valid while rx_valid
overrun_error  out  1  one-cycle pulse: completed frame dropped
break_det  out  1  one-cycle pulse: break condition received

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, synchroniser flops 1. Reset mid-frame aborts the frame; nothing is delivered.
- Input path: rx_in passes a 2-flop synchroniser, giving 2 cycles latency. Start is the synchronised 1->0 edge seen in IDLE.
- Config latching: cfg_* are latched at start detection; changes mid-frame are ignored.
- Config clamping:
  - cfg_prescale < 4 is treated as 4; its LSB is ignored.
  - cfg_data_len is clamped to 5..D_WIDTH_MAX.
- Bit timing: tick counter runs 0..P-1 within each bit. The decision point is tick P/2, taking the sample at tick P/2.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - START: decision 1 -> IDLE (glitch, no output); decision 0 -> DATA.
  - DATA: shifts cfg_data_len bits LSB-first, then goes to PARITY if par_en, else STOP1.
  - PARITY: parity_err = received parity bit != expected parity (even or odd over the data bits).
  - STOP1: decision 0 sets frame_err. Goes to STOP2 if stop2, else completes.
  - STOP2: decision 0 sets frame_err; completes.
- Completion: at the final stop decision point the FSM returns to IDLE immediately, so a start edge in the second half of the stop bit is accepted (resync).
- Break: data all zero, parity bit 0 (if enabled) and STOP1 decision 0.
  - break_det pulses the next cycle.
  - Frame not delivered; no overrun.
  - FSM waits in IDLE for the line to go high before arming start detection.
- Delivery: the cycle after completion, the holding register loads rx_data, parity_error and framing_error, and rx_valid=1.
  - Transfer occurs when rx_valid && rx_ready; rx_valid clears the next cycle unless a new frame loads in that same cycle (load wins, rx_valid stays 1).
  - If a frame completes while rx_valid=1 and rx_ready=0: new frame discarded, holding register unchanged, overrun_error pulses 1 cycle.
- Latency: rx_valid rises 1 cycle after the last stop-bit decision point.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each decision is a 2-of-3 majority of samples at ticks P/2-1, P/2 and P/2+1, taken at tick P/2+1. This rejects a single-tick glitch.
- Undefined: single sample at tick P/2, decided at tick P/2.
- The bit period and the rest of the FSM are identical in both builds.

Decomposition:
- Package uart_pkg: FSM state enum; constants MIN_PRESCALE=4, MIN_DATA_LEN=5; parity type encodings.
- Sub-module uart_rx_sampler: synchroniser, tick counter, sample/majority logic and start-edge detect. Outputs bit_strobe and bit_value.
- FSM, shifter, parity check and holding register stay in uart_rx_mf.

Test Plan:
- 8N1, P=16, send 0xA5, rx_ready=1 -> rx_data=0x0A5, rx_valid pulse 1 cycle after the STOP1 decision, no error flags.
- 7E2, P=8, send 0x55 with wrong parity bit -> rx_data=0x055, parity_error=1; second stop bit 0 -> framing_error=1.
- rx_in low for 3 ticks (P=16) then high -> no rx_valid, FSM back in IDLE, next valid frame 0x3C received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x011, overrun_error pulses once at completion of the 0x22 frame.
- 9 bits, odd parity, P=32, send 0x1FF -> rx_data=0x1FF, no errors. Then hold line low for 2 frame times -> break_det single pulse, no rx_valid.
- UART_RX_MAJORITY_EN, 1-tick inverted glitch at tick P/2 on data bit 3 of 0x00 -> rx_data=0x00. Without the macro the same stimulus -> 0x08.
